lcd_read_ctrl: RTL and testbench

Read-side controller for the HD44780-style character LCD port. It executes LCD read cycles with RW=1: busy-flag/address-counter reads (RS=0) and DDRAM/CGRAM data reads (RS=1). It can optionally poll the busy flag until it clears. It runs on the same divided LCD clock as the init and ASCII-write controllers. While a read is in progress, it claims the LCD pins from the output mux through `bus_req`.

---
 rtl/lcd_read_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lcd_read_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl: HD44780 read-cycle sequencer (BF/AC and DDRAM/CGRAM reads, optional BF polling).
// Define LCD_READ_TIMEOUT_EN to bound busy-flag polling to TIMEOUT_POLLS reads.
module lcd_read_ctrl #(
    parameter int unsigned T_AS          = 1,
    parameter int unsigned T_EH          = 3,
    parameter int unsigned T_EL          = 2,
    parameter int unsigned TIMEOUT_POLLS = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       poll,
    input  logic [7:0] data_in,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_timeout,
    output logic       bus_req,
    output logic       RS,
    output logic       RW,
    output logic       E
);

    localparam int unsigned T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                                  : ((T_EH > T_EL) ? T_EH : T_EL);
    localparam int unsigned CNT_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_E_LOW,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_lat_q, rs_lat_d;
    logic             poll_lat_q, poll_lat_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             bus_q, bus_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic             e_q, e_d;

`ifdef LCD_READ_TIMEOUT_EN
    localparam int unsigned POLL_W = ($clog2(TIMEOUT_POLLS + 1) < 1) ? 1 : $clog2(TIMEOUT_POLLS + 1);
    logic [POLL_W-1:0] polls_q, polls_d;
    logic              bt_q, bt_d;
`endif

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs_lat_d   = rs_lat_q;
        poll_lat_d = poll_lat_q;
        data_d     = data_q;
`ifdef LCD_READ_TIMEOUT_EN
        polls_d    = polls_q;
        bt_d       = bt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    rs_lat_d   = rd_rs;
                    poll_lat_d = poll & ~rd_rs;
                    cnt_d      = CNT_W'(T_AS - 1);
                    state_d    = S_SETUP;
`ifdef LCD_READ_TIMEOUT_EN
                    polls_d    = '0;
                    bt_d       = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(T_EH - 1);
                    state_d = S_E_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_E_HIGH: begin
                if (cnt_q == '0) begin
                    data_d  = data_in;
                    cnt_d   = CNT_W'(T_EL - 1);
                    state_d = S_E_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_E_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (poll_lat_q && data_q[7]) begin
`ifdef LCD_READ_TIMEOUT_EN
                    // Give up once TIMEOUT_POLLS consecutive reads saw BF=1
                    if (polls_q == POLL_W'(TIMEOUT_POLLS - 1)) begin
                        bt_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        polls_d = polls_q + POLL_W'(1);
                        cnt_d   = CNT_W'(T_AS - 1);
                        state_d = S_SETUP;
                    end
`else
                    cnt_d   = CNT_W'(T_AS - 1);
                    state_d = S_SETUP;
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        bus_d   = (state_d == S_SETUP) || (state_d == S_E_HIGH) || (state_d == S_E_LOW);
        rw_d    = bus_d;
        rs_d    = bus_d & rs_lat_d;
        e_d     = (state_d == S_E_HIGH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rs_lat_q   <= 1'b0;
            poll_lat_q <= 1'b0;
            data_q     <= 8'h00;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            bus_q      <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            e_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_lat_q   <= rs_lat_d;
            poll_lat_q <= poll_lat_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            bus_q      <= bus_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            e_q        <= e_d;
        end
    end

`ifdef LCD_READ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            polls_q <= '0;
            bt_q    <= 1'b0;
        end else begin
            polls_q <= polls_d;
            bt_q    <= bt_d;
        end
    end
    assign busy_timeout = bt_q;
`else
    assign busy_timeout = 1'b0;
`endif

    assign rd_ready = ready_q;
    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign bus_req  = bus_q;
    assign RS       = rs_q;
    assign RW       = rw_q;
    assign E        = e_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: random reads checked against a transaction-level model.
module tb_lcd_read_ctrl;

    localparam int unsigned T_AS   = 1;
    localparam int unsigned T_EH   = 3;
    localparam int unsigned T_EL   = 2;
    localparam int unsigned RD_CYC = T_AS + T_EH + T_EL;
`ifdef LCD_READ_TIMEOUT_EN
    localparam int unsigned TP = 4;
`else
    localparam int unsigned TP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rd_req = 1'b0;
    logic       rd_rs = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_ready, rd_valid, busy_timeout, bus_req, RS, RW, E;
    logic [7:0] rd_data;

    lcd_read_ctrl #(
        .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .TIMEOUT_POLLS((TP == 0) ? 255 : TP)
    ) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_rs(rd_rs), .poll(poll),
        .data_in(data_in), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy_timeout(busy_timeout), .bus_req(bus_req), .RS(RS), .RW(RW), .E(E)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       to;
        int         vcyc;
        int         nreads;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  cur_rs = 1'b0;
    int  rst_req = 0, rst_seen = 0;
    int  to_req = 0, to_seen = 0;
    bit  fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: each new E pulse presents the next byte of the current transaction
    always @(posedge E) begin
        if (byte_q.size() > 0) data_in = byte_q.pop_front();
    end

    // Reference: reads continue while polling a busy status, capped at TP reads when enabled
    function automatic void model(input bit rs, input bit pl, input logic [7:0] b[$],
                                  output logic [7:0] d, output logic to, output int n);
        logic [7:0] cur;
        d = 8'h00; to = 1'b0; n = 0;
        for (int i = 0; i < b.size(); i++) begin
            cur = b[i];
            n   = i + 1;
            d   = cur;
            if (!(pl && !rs && cur[7])) return;
            if (TP != 0 && n == int'(TP)) begin
                to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: sole checker; pops the scoreboard on each rd_valid
    int   epulses = 0;
    logic prev_e = 1'b0;
    int   ready_chk = -1;
    logic exp_bt = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            check("rst_ready", 32'(rd_ready), 32'd1);
            check("rst_data", 32'(rd_data), 32'h00);
            check("rst_pins", 32'({bus_req, RS, RW, E, rd_valid, busy_timeout}), 32'd0);
        end
        if (to_req != to_seen) begin
            to_seen = to_req;
            check("wait_budget", 32'd0, 32'd1);
        end
        if (reset) begin
            epulses = 0;
            exp_bt  = 1'b0;
        end else begin
            if (E && !prev_e) epulses++;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e.data));
                    check("timeout_flag", 32'(busy_timeout), 32'(e.to));
                    check("valid_cycle", 32'(cyc), 32'(e.vcyc));
                    check("e_pulses", 32'(epulses), 32'(e.nreads));
                    exp_bt = e.to;
                end
                epulses   = 0;
                ready_chk = cyc + 1;
            end
            if (cyc == ready_chk) check("ready_after", 32'(rd_ready), 32'd1);
            if (bus_req) begin
                check("rs_hold", 32'(RS), 32'(cur_rs));
                check("rw_high", 32'(RW), 32'd1);
                check("ready_low", 32'(rd_ready), 32'd0);
                check("bt_cleared", 32'(busy_timeout), 32'd0);
            end else begin
                check("idle_rw_e", 32'({RW, E}), 32'd0);
                if (!rd_valid) check("bt_sticky", 32'(busy_timeout), 32'(exp_bt));
            end
        end
        prev_e = E;
        if (fin) begin
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!rd_ready && g < 100) begin
            tick();
            g++;
        end
        if (!rd_ready) to_req++;
    endtask

    task automatic do_read(input bit rs, input bit pl, input logic [7:0] bytes[$], input bit noise);
        exp_t e;
        int   g = 0;
        wait_ready();
        model(rs, pl, bytes, e.data, e.to, e.nreads);
        e.vcyc = cyc + 1 + int'(RD_CYC) * e.nreads;
        byte_q = bytes;
        cur_rs = rs;
        exp_q.push_back(e);
        rd_req = 1'b1; rd_rs = rs; poll = pl;
        tick();
        rd_req = 1'b0; rd_rs = 1'($urandom); poll = 1'($urandom);
        if (noise) begin
            tick();
            tick(); rd_req = 1'b1;
            tick(); rd_req = 1'b0;
            tick(); rd_req = 1'b1;
            tick(); rd_req = 1'b0;
        end
        while (exp_q.size() != 0 && g < 2000) begin
            tick();
            g++;
        end
        if (exp_q.size() != 0) to_req++;
        tick();
    endtask

    initial begin
        logic [7:0] b[$];
        int nb, g;
        bit rs, pl;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b[$];
        int  nb;
        int  g;
        bit  rs, pl;
        repeat (3) @(posedge clk);
        #1;
        rst_req++;
        tick();
        reset = 1'b0;
        tick();

        // Reset while E is high during a data read
        byte_q = '{8'h41};
        cur_rs = 1'b1;
        rd_req = 1'b1; rd_rs = 1'b1; poll = 1'b0;
        tick();
        rd_req = 1'b0;
        g = 0;
        while (!E && g < 20) begin
            tick();
            g++;
        end
        if (!E) to_req++;
        reset = 1'b1;
        tick();
        rst_req++;
        tick();
        reset = 1'b0;
        byte_q.delete();
        repeat (10) tick();

        do_read(1'b1, 1'b0, '{8'h41}, 1'b0);
        do_read(1'b0, 1'b0, '{8'h85}, 1'b0);
        do_read(1'b0, 1'b1, '{8'h80, 8'h80, 8'h80, 8'h0C}, 1'b0);
        do_read(1'b1, 1'b0, '{8'h5A}, 1'b1);
`ifdef LCD_READ_TIMEOUT_EN
        do_read(1'b0, 1'b1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);
        repeat (5) tick();
        do_read(1'b0, 1'b1, '{8'h81, 8'h03}, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            pl = 1'($urandom);
            b.delete();
            if (rs || !pl) begin
                b.push_back(8'($urandom));
            end else begin
                nb = (TP == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TP));
                for (int k = 0; k < nb; k++) b.push_back(8'($urandom) | 8'h80);
                b.push_back(8'($urandom) & 8'h7F);
            end
            do_read(rs, pl, b, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();
        fin = 1'b1;
    end

endmodule
